// File: rtl/alu_ctl_md.sv
// alu_ctl_md -- EX-stage ALU control with an iterative multiply/divide unit.
//
// Decodes ALUop/func into the 4-bit ALU control code and the result-mux
// select. Also runs mult/multu/div/divu one bit per cycle and owns the
// HI/LO registers, including mthi/mtlo writes.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   valid             EX-stage instruction valid
//   ALUop, func       main-control op class and R-type function field
//   op_a, op_b        rs / rt operand values
//   ALUCtl            ALU control code (combinational)
//   sel_hilo          result select: 0 ALU, 1 HI, 2 LO (combinational)
//   stall             hold EX and earlier stages (combinational)
//   busy              sequencer not idle
//   hi, lo            HI/LO registers
//   md_done           one-cycle pulse after a mult/div result is written
//   div_by_zero       one-cycle pulse alongside md_done for a zero divisor
module alu_ctl_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALUCtl,
  output logic [1:0]       sel_hilo,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_reg;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw_reg;    // dividend as presented, returned on divide by zero
  logic               is_div_reg;
  logic               neg_q_reg;    // negate product / quotient
  logic               neg_r_reg;    // negate remainder
  logic               dz_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               dbz_reg;

  // ---------------- combinational decode ----------------
  logic is_rtype;
  logic is_hilo_op;
  logic accept;
  logic start;
  logic signed_op;
  logic sa;
  logic sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign is_rtype   = (ALUop == 2'd2);
  assign is_hilo_op = is_rtype && (func inside {6'd16, 6'd17, 6'd18, 6'd19,
                                                6'd24, 6'd25, 6'd26, 6'd27});
  assign busy       = (state_reg != S_IDLE);
  assign stall      = valid && busy && is_hilo_op;
  assign accept     = valid && !busy;
  // func 24..27 share the pattern 0110xx; bit 1 selects divide, bit 0 unsigned
  assign start      = accept && is_rtype && (func[5:2] == 4'b0110);
  assign signed_op  = !func[0];
  assign sa         = signed_op && op_a[WIDTH-1];
  assign sb         = signed_op && op_b[WIDTH-1];
  assign mag_a      = sa ? -op_a : op_a;
  assign mag_b      = sb ? -op_b : op_b;

  always_comb begin
    ALUCtl = 4'd15;
    case (ALUop)
      2'd0: ALUCtl = 4'd2;
      2'd1: ALUCtl = 4'd6;
      2'd2: begin
        case (func)
          6'd32:   ALUCtl = 4'd2;
          6'd34:   ALUCtl = 4'd6;
          6'd36:   ALUCtl = 4'd0;
          6'd37:   ALUCtl = 4'd1;
          6'd39:   ALUCtl = 4'd12;
          6'd42:   ALUCtl = 4'd7;
          default: ALUCtl = 4'd15;
        endcase
      end
      default: ALUCtl = 4'd15;
    endcase
  end

  always_comb begin
    sel_hilo = 2'd0;
    if (is_rtype && func == 6'd16) sel_hilo = 2'd1;
    else if (is_rtype && func == 6'd18) sel_hilo = 2'd2;
  end

  // ---------------- iteration datapath ----------------
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_next;
  assign addend   = acc_reg[0] ? opnd_reg : {WIDTH{1'b0}};
  assign madd     = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mul_next = {madd, acc_reg[WIDTH-1:1]};

  // Restoring divide: trial-subtract from the remainder shifted left by one,
  // keep the difference when it is non-negative, and shift in the quotient bit.
  logic [WIDTH:0]     trial;
  logic               qbit;
  logic [2*WIDTH-1:0] div_next;
  assign trial    = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};
  assign qbit     = !trial[WIDTH];
  assign div_next = {(qbit ? trial[WIDTH-1:0] : acc_reg[2*WIDTH-2:WIDTH-1]),
                     acc_reg[WIDTH-2:0], qbit};

  // Sign correction / special cases applied on the FIX edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (dz_reg) begin
        fix_hi = a_raw_reg;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        fix_lo = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      end
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      a_raw_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            is_div_reg <= func[1];
            neg_q_reg  <= sa ^ sb;
            neg_r_reg  <= sa;
            dz_reg     <= (op_b == '0);
            a_raw_reg  <= op_a;
            acc_reg    <= func[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd_reg   <= func[1] ? mag_b : mag_a;
            cnt_reg    <= '0;
            state_reg  <= S_RUN;
          end else if (accept && is_rtype && func == 6'd17) begin
            hi_reg <= op_a;
          end else if (accept && is_rtype && func == 6'd19) begin
            lo_reg <= op_a;
          end
        end
        S_RUN: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) state_reg <= S_FIX;
        end
        S_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          done_reg  <= 1'b1;
          dbz_reg   <= is_div_reg && dz_reg;
          cnt_reg   <= '0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign md_done     = done_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_ctl_md.sv
// tb_alu_ctl_md -- directed self-checking bench for alu_ctl_md (WIDTH=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_alu_ctl_md;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [1:0]  ALUop;
  logic [5:0]  func;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  ALUCtl;
  logic [1:0]  sel_hilo;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;

  always #5 clk = ~clk;

  alu_ctl_md #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUop(ALUop), .func(func),
    .op_a(op_a), .op_b(op_b), .ALUCtl(ALUCtl), .sel_hilo(sel_hilo),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo), .md_done(md_done),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div op, scramble operands afterwards, count busy cycles.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    ALUop = 2'd2; func = f; op_a = a; op_b = b; valid = 1'b1;
    tick();
    valid = 1'b0; func = 6'd0; op_a = $urandom; op_b = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  int dec_func [10] = '{32, 34, 36, 37, 39, 42, 0, 16, 18, 24};
  int dec_ctl  [10] = '{2, 6, 0, 1, 12, 7, 15, 15, 15, 15};
  int dec_sel  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 0};
  int aop_ctl  [4]  = '{2, 6, 15, 15};

  initial begin
    reset = 1'b1; valid = 1'b0; ALUop = 2'd0; func = 6'd0; op_a = '0; op_b = '0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_done", md_done, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // decode sweep
    for (int i = 0; i < 10; i++) begin
      ALUop = 2'd2; func = 6'(dec_func[i]); #1;
      check($sformatf("ctl_f%0d", dec_func[i]), ALUCtl, dec_ctl[i]);
      check($sformatf("sel_f%0d", dec_func[i]), sel_hilo, dec_sel[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) continue;
      ALUop = 2'(i); func = 6'd16; #1;
      check($sformatf("ctl_aop%0d", i), ALUCtl, aop_ctl[i]);
      check($sformatf("sel_aop%0d", i), sel_hilo, 0);
    end

    // valid low: mult not accepted
    ALUop = 2'd2; func = 6'd24; op_a = 32'd3; op_b = 32'd5; valid = 1'b0;
    tick(); tick();
    check("novalid_busy", busy, 0);

    // multu max*max with mfhi queued behind it
    ALUop = 2'd2; func = 6'd25; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; valid = 1'b1;
    tick();
    func = 6'd16; op_a = 32'd0; op_b = 32'd0;
    n = 0;
    while (stall && n < 100) begin
      n++;
      check("multu_busy_during", busy, 1);
      tick();
    end
    check("mfhi_stall_cycles", n, 33);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    check("multu_done", md_done, 1);
    check("mfhi_sel", sel_hilo, 1);
    check("mfhi_stall_low", stall, 0);
    tick();
    valid = 1'b0;
    check("multu_done_drop", md_done, 0);

    run_md(6'd24, 32'hFFFFFFFD, 32'd5, n);
    check("mult_cycles", n, 33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);
    check("mult_done", md_done, 1);

    run_md(6'd26, 32'hFFFFFFF9, 32'd2, n);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_dbz", div_by_zero, 0);

    run_md(6'd27, 32'd7, 32'd3, n);
    check("divu_lo", lo, 32'd2);
    check("divu_hi", hi, 32'd1);

    run_md(6'd27, 32'd7, 32'd0, n);
    check("divz_lo", lo, 32'hFFFFFFFF);
    check("divz_hi", hi, 32'd7);
    check("divz_flag", div_by_zero, 1);
    check("divz_done", md_done, 1);
    tick();
    check("divz_flag_drop", div_by_zero, 0);

    run_md(6'd26, 32'h80000000, 32'hFFFFFFFF, n);
    check("ovf_lo", lo, 32'h80000000);
    check("ovf_hi", hi, 32'd0);
    check("ovf_flag", div_by_zero, 0);
    check("ovf_done", md_done, 1);

    // mtlo while idle
    ALUop = 2'd2; func = 6'd19; op_a = 32'h1234; valid = 1'b1; #1;
    check("mtlo_stall", stall, 0);
    tick();
    valid = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_busy", busy, 0);

    // mthi while busy
    ALUop = 2'd2; func = 6'd25; op_a = 32'd2; op_b = 32'd3; valid = 1'b1;
    tick();
    func = 6'd17; op_a = 32'hABCD;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    check("mthi_stall_cycles", n, 33);
    check("mthi_pre_hi", hi, 32'd0);
    tick();
    valid = 1'b0;
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_lo", lo, 32'd6);
    check("mthi_busy", busy, 0);

    // reset mid-RUN
    ALUop = 2'd2; func = 6'd24; op_a = 32'd3; op_b = 32'd5; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (10) tick();
    check("prereset_busy", busy, 1);
    reset = 1'b1; #1;
    check("midreset_busy", busy, 0);
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    tick();
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      tick();
      if (md_done) pulses++;
    end
    check("aborted_no_done", pulses, 0);
    check("aborted_busy", busy, 0);

    run_md(6'd27, 32'd100, 32'd7, n);
    check("post_divu_cycles", n, 33);
    check("post_divu_lo", lo, 32'd14);
    check("post_divu_hi", hi, 32'd2);
    check("post_divu_done", md_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
